i2sm_tdm_tx: RTL and testbench

I2SM_TDM_TX -- requirements
Module: i2sm_tdm_tx

---
 rtl/i2sm_tdm_tx.sv | 160 ++++++++++++++++
 tb/tb_i2sm_tdm_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2sm_tdm_tx.sv
// i2sm_tdm_tx: TDM / I2S serial audio transmitter (bit-clock master).
// One frame of NCH samples is accepted per NCH*SLOT_W bit periods and
// shifted out MSB-first on sdo. sclk, lrclk and sdo are all registered.
// Optional build macro: I2SM_TDM_TX_HOLD_EN -- on underrun, retransmit the
// last accepted frame instead of an all-zero frame.
module i2sm_tdm_tx #(
   parameter int unsigned DW       = 24,
   parameter int unsigned SLOT_W   = 32,
   parameter int unsigned NCH      = 2,
   parameter int unsigned SCLK_DIV = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              fmt,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [NCH*DW-1:0] s_data,
   output logic              sclk,
   output logic              lrclk,
   output logic              sdo,
   output logic              underrun
);

   localparam int unsigned BITP    = 2 * SCLK_DIV;
   localparam int unsigned DIV_W   = $clog2(BITP);
   localparam int unsigned BIT_W   = $clog2(SLOT_W);
   localparam int unsigned SLOT_CW = $clog2(NCH);
   localparam int unsigned FW      = NCH * DW;
   localparam int unsigned IDX_W   = $clog2(FW);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t               r_state;
   logic [DIV_W-1:0]     r_div;
   logic [BIT_W-1:0]     r_bit;
   logic [SLOT_CW-1:0]   r_slot;
   logic [FW-1:0]        r_frame;
   logic                 r_fmt;
   logic                 r_dly;
   logic                 r_sclk;
   logic                 r_lrclk;
   logic                 r_sdo;
   logic                 r_ready;
   logic                 r_urun;

   logic                 w_start;
   logic [FW-1:0]        w_frame;
   logic                 w_fmt;
   logic [DIV_W-1:0]     w_div;
   logic [BIT_W-1:0]     w_bit;
   logic [SLOT_CW-1:0]   w_slot;
   logic                 w_last;
   logic [IDX_W-1:0]     w_sel;
   logic                 w_lj;

   // Next frame position, next frame contents and the left-justified bit there
   always_comb begin
      w_start = r_ready;
      w_frame = r_frame;
      w_fmt   = r_fmt;
      w_div   = r_div;
      w_bit   = r_bit;
      w_slot  = r_slot;
      if (w_start) begin
         w_fmt = fmt;
         if (s_valid) begin
            w_frame = s_data;
         end else begin
`ifdef I2SM_TDM_TX_HOLD_EN
            w_frame = r_frame;
`else
            w_frame = '0;
`endif
         end
         w_div  = '0;
         w_bit  = '0;
         w_slot = '0;
      end else if (r_div == DIV_W'(BITP - 1)) begin
         w_div = '0;
         if (r_bit == BIT_W'(SLOT_W - 1)) begin
            w_bit  = '0;
            w_slot = (r_slot == SLOT_CW'(NCH - 1)) ? '0 : r_slot + SLOT_CW'(1);
         end else begin
            w_bit = r_bit + BIT_W'(1);
         end
      end else begin
         w_div = r_div + DIV_W'(1);
      end
      w_last = (w_div == DIV_W'(BITP - 1)) && (w_bit == BIT_W'(SLOT_W - 1)) &&
               (w_slot == SLOT_CW'(NCH - 1));
      w_sel  = IDX_W'(32'(w_slot) * DW + DW - 1 - 32'(w_bit));
      w_lj   = (32'(w_bit) < DW) ? w_frame[w_sel] : 1'b0;
   end

   // Sequencer: idle -> one s_ready cycle -> frames back to back while en=1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_slot  <= '0;
         r_frame <= '0;
         r_fmt   <= 1'b0;
         r_dly   <= 1'b0;
         r_sclk  <= 1'b0;
         r_lrclk <= 1'b0;
         r_sdo   <= 1'b0;
         r_ready <= 1'b0;
         r_urun  <= 1'b0;
      end else if (!en) begin
         r_state <= ST_IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_slot  <= '0;
         r_dly   <= 1'b0;
         r_sclk  <= 1'b0;
         r_lrclk <= 1'b0;
         r_sdo   <= 1'b0;
         r_ready <= 1'b0;
         r_urun  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ready <= 1'b1;
               r_urun  <= 1'b0;
               r_state <= ST_SYNC;
            end
            default: begin
               r_state <= ST_RUN;
               r_div   <= w_div;
               r_bit   <= w_bit;
               r_slot  <= w_slot;
               r_frame <= w_frame;
               r_fmt   <= w_fmt;
               r_ready <= w_last;
               r_urun  <= w_start && !s_valid;
               r_sclk  <= (w_div >= DIV_W'(SCLK_DIV));
               r_lrclk <= (32'(w_slot) >= NCH / 2);
               // sdo only moves at the start of a bit period (sclk falling)
               if (w_div == '0) begin
                  r_sdo <= w_fmt ? w_lj : r_dly;
                  r_dly <= w_lj;
               end
            end
         endcase
      end
   end

   assign s_ready  = r_ready;
   assign underrun = r_urun;
   assign sclk     = r_sclk;
   assign lrclk    = r_lrclk;
   assign sdo      = r_sdo;

endmodule

// File: tb/tb_i2sm_tdm_tx.sv
// Directed bench for i2sm_tdm_tx: default 2-slot instance plus an 8-slot,
// SCLK_DIV=1 instance. Slot words are captured on sclk rising edges.
module tb_i2sm_tdm_tx;

   localparam int unsigned SW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          fmt = 1'b1;
   logic          s_valid = 1'b1;
   logic [47:0]   s_data = '0;
   logic          s_ready_a, sclk_a, lrclk_a, sdo_a, underrun_a;

   logic          s_valid_b = 1'b1;
   logic          fmt_b = 1'b1;
   logic [191:0]  s_data_b = {24'h888888, 24'h777777, 24'h666666, 24'h555555,
                             24'h444444, 24'h333333, 24'h222222, 24'h111111};
   logic          s_ready_b, sclk_b, lrclk_b, sdo_b, underrun_b;

   logic          sel_b = 1'b0;
   logic          m_rdy, m_sclk, m_lr, m_sdo, m_urun;

   int            checks = 0;
   int            errors = 0;

   logic [31:0]   cw [8];
   int            c_lrl, c_lrh, c_rise, c_bad, c_rdy_cnt, c_urun_cnt;
   logic          c_rdy_last, c_urun0;
   logic [7:0]    c_lrmask;

   i2sm_tdm_tx u_dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .fmt(fmt), .s_valid(s_valid),
      .s_ready(s_ready_a), .s_data(s_data), .sclk(sclk_a), .lrclk(lrclk_a),
      .sdo(sdo_a), .underrun(underrun_a)
   );

   i2sm_tdm_tx #(.DW(24), .SLOT_W(32), .NCH(8), .SCLK_DIV(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .fmt(fmt_b), .s_valid(s_valid_b),
      .s_ready(s_ready_b), .s_data(s_data_b), .sclk(sclk_b), .lrclk(lrclk_b),
      .sdo(sdo_b), .underrun(underrun_b)
   );

   assign m_rdy  = sel_b ? s_ready_b  : s_ready_a;
   assign m_sclk = sel_b ? sclk_b     : sclk_a;
   assign m_lr   = sel_b ? lrclk_b    : lrclk_a;
   assign m_sdo  = sel_b ? sdo_b      : sdo_a;
   assign m_urun = sel_b ? underrun_b : underrun_a;

   always #5 clk = ~clk;

   // Count one comparison and report it on mismatch
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy(input string tag);
      int n = 0;
      while (!m_rdy && n < 2000) begin
         tick;
         n++;
      end
      chk({tag, "_rdy_seen"}, 64'(m_rdy), 64'd1);
   endtask

   // Capture one frame starting in the s_ready cycle; optionally flip fmt mid-frame
   task automatic cap(input int ncyc, input int per, input int tog_at, input logic tog_val);
      logic ps, psck;
      int   slot;
      for (int k = 0; k < 8; k++) cw[k] = '0;
      c_lrl = 0; c_lrh = 0; c_rise = 0; c_bad = 0; c_rdy_cnt = 0; c_urun_cnt = 0;
      c_rdy_last = 1'b0; c_urun0 = 1'b0; c_lrmask = '0;
      ps = m_sdo;
      psck = m_sclk;
      for (int i = 0; i < ncyc; i++) begin
         tick;
         if (m_lr) c_lrh++; else c_lrl++;
         if (m_sclk && !psck) begin
            slot = c_rise / SW;
            if (slot < 8) begin
               cw[slot] = {cw[slot][30:0], m_sdo};
               if ((c_rise % SW) == 0) c_lrmask[slot] = m_lr;
            end
            c_rise++;
         end
         if ((m_sdo !== ps) && ((i % per) != 0)) c_bad++;
         if (m_rdy) c_rdy_cnt++;
         if (i == ncyc - 1) c_rdy_last = m_rdy;
         if (m_urun) c_urun_cnt++;
         if (i == 0) c_urun0 = m_urun;
         ps = m_sdo;
         psck = m_sclk;
         if (i == tog_at) fmt = tog_val;
      end
   endtask

   task automatic chk_frame(input string tag, input logic [7:0] mask, input int ncyc, input int per);
      chk({tag, "_lr_low"},   64'(c_lrl), 64'(ncyc / 2));
      chk({tag, "_lr_high"},  64'(c_lrh), 64'(ncyc / 2));
      chk({tag, "_lr_slots"}, 64'(c_lrmask), 64'(mask));
      chk({tag, "_sclk_bits"}, 64'(c_rise), 64'(ncyc / per));
      chk({tag, "_sdo_edge"}, 64'(c_bad), 64'd0);
      chk({tag, "_rdy_cnt"},  64'(c_rdy_cnt), 64'd1);
      chk({tag, "_rdy_last"}, 64'(c_rdy_last), 64'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] acc;
      s_data  = {24'h5A5A5A, 24'hA5A5A5};
      rst_n   = 1'b0;
      en      = 1'b1;
      fmt     = 1'b1;
      s_valid = 1'b1;

      // reset state
      #3;
      chk("rst_out", 64'({sclk_a, lrclk_a, sdo_a, s_ready_a, underrun_a,
                          sclk_b, lrclk_b, sdo_b, s_ready_b, underrun_b}), 64'd0);
      repeat (3) tick;
      chk("rst_hold", 64'({sclk_a, lrclk_a, sdo_a, s_ready_a, underrun_a}), 64'd0);
      rst_n = 1'b1;
      tick;
      chk("start_rdy", 64'(s_ready_a), 64'd1);
      chk("start_out", 64'({sclk_a, lrclk_a, sdo_a}), 64'd0);

      // F1 left-justified; fmt drops to I2S mid-frame and must not affect it
      cap(256, 4, 100, 1'b0);
      chk_frame("f1", 8'h02, 256, 4);
      chk("f1_s0", 64'(cw[0]), 64'h00000000A5A5A500);
      chk("f1_s1", 64'(cw[1]), 64'h000000005A5A5A00);
      chk("f1_urun", 64'(c_urun_cnt), 64'd0);

      // F2 I2S: one-bit delay, wrapped-in bit is 0
      cap(256, 4, -1, 1'b0);
      chk_frame("f2", 8'h02, 256, 4);
      chk("f2_s0", 64'(cw[0]), 64'h0000000052D2D280);
      chk("f2_s1", 64'(cw[1]), 64'h000000002D2D2D00);

      // F3 underrun, back to left-justified
      fmt = 1'b1;
      s_valid = 1'b0;
      cap(256, 4, -1, 1'b1);
      s_valid = 1'b1;
      chk_frame("f3", 8'h02, 256, 4);
      chk("f3_urun0", 64'(c_urun0), 64'd1);
      chk("f3_urun_cnt", 64'(c_urun_cnt), 64'd1);
`ifdef I2SM_TDM_TX_HOLD_EN
      chk("f3_s0", 64'(cw[0]), 64'h00000000A5A5A500);
      chk("f3_s1", 64'(cw[1]), 64'h000000005A5A5A00);
`else
      chk("f3_s0", 64'(cw[0]), 64'd0);
      chk("f3_s1", 64'(cw[1]), 64'd0);
`endif

      // F4 valid again
      cap(256, 4, -1, 1'b1);
      chk("f4_urun_cnt", 64'(c_urun_cnt), 64'd0);
      chk("f4_s0", 64'(cw[0]), 64'h00000000A5A5A500);

      // en dropped mid-frame for 10 cycles
      repeat (100) tick;
      en = 1'b0;
      s_data = {24'hFEDCBA, 24'h123456};
      acc = '0;
      repeat (10) begin
         tick;
         acc[4:0] = acc[4:0] | {sclk_a, lrclk_a, sdo_a, s_ready_a, underrun_a};
      end
      chk("en_off_out", 64'(acc), 64'd0);
      en = 1'b1;
      tick;
      chk("en_rdy", 64'(s_ready_a), 64'd1);
      cap(256, 4, -1, 1'b1);
      chk_frame("f5", 8'h02, 256, 4);
      chk("f5_s0", 64'(cw[0]), 64'h0000000012345600);
      chk("f5_s1", 64'(cw[1]), 64'h00000000FEDCBA00);

      // asynchronous reset mid-frame
      repeat (51) tick;
      chk("pre_rst_sclk", 64'(sclk_a), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst", 64'({sclk_a, lrclk_a, sdo_a, s_ready_a, underrun_a,
                            sclk_b, lrclk_b, sdo_b, s_ready_b, underrun_b}), 64'd0);
      tick;
      tick;
      rst_n = 1'b1;
      tick;
      chk("rst_rdy", 64'(s_ready_a), 64'd1);
      s_valid = 1'b0;
      cap(256, 4, -1, 1'b1);
      s_valid = 1'b1;
      chk("f6_urun0", 64'(c_urun0), 64'd1);
      chk("f6_s0", 64'(cw[0]), 64'd0);
      chk("f6_s1", 64'(cw[1]), 64'd0);
      cap(256, 4, -1, 1'b1);
      chk_frame("f7", 8'h02, 256, 4);
      chk("f7_s0", 64'(cw[0]), 64'h0000000012345600);
      chk("f7_s1", 64'(cw[1]), 64'h00000000FEDCBA00);

      // 8-slot instance, SCLK_DIV=1: 512-cycle frame
      sel_b = 1'b1;
      wait_rdy("b");
      cap(512, 2, -1, 1'b1);
      chk_frame("b", 8'hF0, 512, 2);
      for (int k = 0; k < 8; k++)
         chk($sformatf("b_s%0d", k), 64'(cw[k]), 64'({s_data_b[k*24 +: 24], 8'h00}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
